// File: rtl/maxpool2d_1.sv
// 2x2 stride-2 max pooling over a row-major KERNAL_NUM-channel pixel stream.
// Latency: out_valid asserts one cycle after the 4th pixel of a window is accepted.
// Backpressure: none; every in_valid beat is accepted, and gaps between beats are harmless.
//
// Ports: clk, rst_n (async, active-low); frame_start resets position to (0,0);
//        in_valid/in_data carry input pixels; out_valid/out_data carry pooled pixels;
//        frame_done pulses after the last pixel of a frame; busy spans a frame in flight.
// Build option: define MAXPOOL_AVG_MODE_EN to replace max with floor-average pooling.
module maxpool2d_1 #(
    parameter int DATA_WIDTH = 16,
    parameter int KERNAL_NUM = 6,
    parameter int IN_WIDTH   = 31,
    parameter int IN_HEIGHT  = 31
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             frame_start,
    input  logic                             in_valid,
    input  logic [DATA_WIDTH*KERNAL_NUM-1:0] in_data,
    output logic                             out_valid,
    output logic [DATA_WIDTH*KERNAL_NUM-1:0] out_data,
    output logic                             frame_done,
    output logic                             busy
);
    localparam int OUT_WIDTH  = IN_WIDTH / 2;
    localparam int OUT_HEIGHT = IN_HEIGHT / 2;
    localparam int DW  = DATA_WIDTH;
    localparam int CW  = (IN_WIDTH > 1) ? $clog2(IN_WIDTH) : 1;
    localparam int RW  = (IN_HEIGHT > 1) ? $clog2(IN_HEIGHT) : 1;
    localparam int IW  = (OUT_WIDTH > 1) ? $clog2(OUT_WIDTH) : 1;
`ifdef MAXPOOL_AVG_MODE_EN
    localparam int LBW = DW + 1;    // line buffer keeps the un-truncated 2-sample sum
`else
    localparam int LBW = DW;
`endif

    localparam bit W_ODD = (IN_WIDTH != 2 * OUT_WIDTH);
    localparam bit H_ODD = (IN_HEIGHT != 2 * OUT_HEIGHT);
    localparam logic [CW-1:0] COL_LAST = CW'(IN_WIDTH - 1);
    localparam logic [CW-1:0] EDGE_COL = CW'(2 * OUT_WIDTH);       // unpaired last column
    localparam logic [RW-1:0] ROW_LAST = RW'(IN_HEIGHT - 1);
    localparam logic [RW-1:0] PRE_DROP = RW'(2 * OUT_HEIGHT - 1);  // row before the unpaired last row

    typedef enum logic [1:0] {IDLE, ROW_EVEN, ROW_ODD, ROW_DROP} state_t;
    localparam state_t FIRST_KIND = (IN_HEIGHT == 1) ? ROW_DROP : ROW_EVEN;

    state_t                       state, cur_state, kind, next_kind;
    logic [CW-1:0]                col_cnt, cur_col;
    logic [RW-1:0]                row_cnt, cur_row;
    logic                         col_last, row_last, edge_col, lb_we;
    logic [IW-1:0]                lb_idx;
    logic [KERNAL_NUM*DW-1:0]     hold, result;
    logic [KERNAL_NUM*LBW-1:0]    pair, lb_rd;
    logic [KERNAL_NUM*LBW-1:0]    linebuf [OUT_WIDTH];

    // Horizontal pair of one channel: max, or sign-extended sum in average mode.
    function automatic logic [LBW-1:0] pair_f(input logic [DW-1:0] a, input logic [DW-1:0] b);
`ifdef MAXPOOL_AVG_MODE_EN
        return {a[DW-1], a} + {b[DW-1], b};
`else
        return ($signed(a) > $signed(b)) ? a : b;
`endif
    endfunction

    // Combine the stored upper pair with the lower pair of one channel.
    function automatic logic [DW-1:0] pool_f(input logic [LBW-1:0] l, input logic [DW-1:0] a,
                                             input logic [DW-1:0] b);
`ifdef MAXPOOL_AVG_MODE_EN
        logic [DW+1:0] s;
        s = {l[DW], l} + {{2{a[DW-1]}}, a} + {{2{b[DW-1]}}, b};
        return s[DW+1:2];   // arithmetic >>2 (floor) then truncate
`else
        logic [DW-1:0] p;
        p = pair_f(a, b);
        return ($signed(l) > $signed(p)) ? l : p;
`endif
    endfunction

    // frame_start acts on the same beat: a coincident pixel is taken as (0,0).
    always_comb begin
        cur_state = frame_start ? IDLE : state;
        cur_col   = frame_start ? '0 : col_cnt;
        cur_row   = frame_start ? '0 : row_cnt;
        kind      = (cur_state == IDLE) ? FIRST_KIND : cur_state;
        col_last  = (cur_col == COL_LAST);
        row_last  = (cur_row == ROW_LAST);
        edge_col  = W_ODD && (cur_col == EDGE_COL);
        if (kind == ROW_ODD)
            next_kind = (H_ODD && (cur_row == PRE_DROP)) ? ROW_DROP : ROW_EVEN;
        else
            next_kind = ROW_ODD;
        lb_idx    = IW'(cur_col >> 1);
        lb_we     = in_valid && (kind == ROW_EVEN) && cur_col[0];
        lb_rd     = linebuf[lb_idx];
    end

    always_comb begin
        pair   = '0;
        result = '0;
        for (int j = 0; j < KERNAL_NUM; j++) begin
            pair[j*LBW +: LBW] = pair_f(hold[j*DW +: DW], in_data[j*DW +: DW]);
            result[j*DW +: DW] = pool_f(lb_rd[j*LBW +: LBW], hold[j*DW +: DW], in_data[j*DW +: DW]);
        end
    end

    // Line buffer contents need no reset: every entry is written before it is read.
    always_ff @(posedge clk) begin
        if (lb_we)
            linebuf[lb_idx] <= pair;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            col_cnt    <= '0;
            row_cnt    <= '0;
            hold       <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            frame_done <= 1'b0;
            busy       <= 1'b0;
        end else begin
            out_valid  <= 1'b0;
            frame_done <= 1'b0;
            if (in_valid) begin
                busy <= 1'b1;
                if ((kind == ROW_EVEN || kind == ROW_ODD) && !cur_col[0] && !edge_col)
                    hold <= in_data;
                if (kind == ROW_ODD && cur_col[0]) begin
                    out_valid <= 1'b1;
                    out_data  <= result;
                end
                if (col_last) begin
                    col_cnt <= '0;
                    if (row_last) begin
                        row_cnt    <= '0;
                        state      <= IDLE;
                        busy       <= 1'b0;
                        frame_done <= 1'b1;
                    end else begin
                        row_cnt <= cur_row + RW'(1);
                        state   <= next_kind;
                    end
                end else begin
                    col_cnt <= cur_col + CW'(1);
                    row_cnt <= cur_row;
                    state   <= kind;
                end
            end else if (frame_start) begin
                // Abandon any partial frame without signalling frame_done.
                state   <= IDLE;
                col_cnt <= '0;
                row_cnt <= '0;
                busy    <= 1'b0;
            end
        end
    end
endmodule

// File: doc/maxpool2d_1.md
Name: maxpool2d_1

Overview:
- 2x2, stride-2 max-pooling stage directly downstream of the first convolution layer.
- Consumes the conv layer's per-pixel ReLU output bus: KERNAL_NUM channels in parallel, one feature-map pixel per valid beat, row-major.
- Produces the pooled feature map in the same bus format for the next (conv2) stage.
- Holds one half-width line buffer internally; no external memory.

Parameters:
- DATA_WIDTH, 16, width of one channel sample (signed two's complement fixed point).
- KERNAL_NUM, 6, number of parallel channels on the bus.
- IN_WIDTH, 31, input feature-map width in pixels (35 - 5 + 1).
- IN_HEIGHT, 31, input feature-map height in pixels.
- OUT_WIDTH, IN_WIDTH/2 (floor), output width; derived, not overridable.
- OUT_HEIGHT, IN_HEIGHT/2 (floor), output height; derived, not overridable.

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- frame_start  input  1  single-cycle sync pulse; clears position counters, next accepted pixel is (0,0)
- in_valid  input  1  in_data holds a valid pixel this cycle
- in_data  input  DATA_WIDTH*KERNAL_NUM  channel j at bits [DATA_WIDTH*(j+1)-1 : DATA_WIDTH*j]
- out_valid  output  1  out_data holds a pooled pixel
- out_data  output  DATA_WIDTH*KERNAL_NUM  pooled pixel, same channel packing as in_data
- frame_done  output  1  one-cycle pulse after the last input pixel of a frame is accepted
- busy  output  1  high from the first accepted pixel until frame_done

Behaviour:
- Reset: clk is the only clock; rst_n is asynchronous and active-low. While rst_n is low, out_valid=0, out_data=0, frame_done=0, busy=0, counters=0, state=IDLE. Line-buffer contents are don't-care.
- Counters: col_cnt (0..IN_WIDTH-1) and row_cnt (0..IN_HEIGHT-1) advance only on in_valid. Gaps between in_valid beats are allowed and have no effect on results.
- States:
  - IDLE: entered on reset or after frame_done. The first in_valid beat moves to ROW_EVEN.
  - ROW_EVEN: row_cnt even, not the last row.
  - ROW_ODD: row_cnt odd.
  - ROW_DROP: row_cnt = IN_HEIGHT-1 when IN_HEIGHT is odd; inputs are accepted, counted and discarded.
- Row transitions: on col_cnt wrap, ROW_EVEN -> ROW_ODD. ROW_ODD -> ROW_EVEN, or -> ROW_DROP if the next row is the odd last row, or -> IDLE at frame end. ROW_DROP -> IDLE at frame end.
- ROW_EVEN, even col: register the pixel as hold.
- ROW_EVEN, odd col: write max(hold, pixel) per channel into linebuf[col_cnt>>1].
- ROW_ODD, even col: register the pixel as hold.
- ROW_ODD, odd col: result = max(linebuf[col_cnt>>1], max(hold, pixel)) per channel, registered to out_data. out_valid=1 for exactly one cycle.
- Odd-width edge: col_cnt = IN_WIDTH-1 with IN_WIDTH odd is ignored in every state; no write and no output.
- Comparison: signed, per channel, independent lanes. Ties select either operand (values are equal).
- Latency: out_valid is asserted in the cycle after the 4th contributing pixel is accepted.
- Output count: exactly OUT_WIDTH*OUT_HEIGHT out_valid pulses per frame (225 at defaults).
- out_data holds its last value while out_valid=0.
- Frame end: frame_done pulses in the cycle after pixel (IN_HEIGHT-1, IN_WIDTH-1) is accepted. At that point busy drops, counters return to 0 and state goes to IDLE.
- frame_start: clears counters and state to IDLE. If it coincides with in_valid, that pixel is taken as (0,0). Mid-frame, the partial frame is abandoned and frame_done does not fire for it.
- Extra beats: in_valid in IDLE with no frame_start starts a new frame at (0,0).
- Reset mid-frame: all state cleared and no further output; the next frame starts clean.

Optional Feature:
- Macro: MAXPOOL_AVG_MODE_EN.
- Defined: average pooling replaces max. Per channel, the four samples are summed sign-extended to DATA_WIDTH+2 bits. The even row stores the 2-sample sum in a DATA_WIDTH+1-bit line buffer. The result is the sum arithmetically shifted right by 2 (floor), truncated to DATA_WIDTH. Latency and handshake are unchanged.
- Undefined: max pooling as above; the line buffer is DATA_WIDTH per channel.

Test Plan:
- Defaults; frame with channel j pixel(r,c) = r*31+c+j -> 225 outputs; output (0,0) ch0 = 32 (pixel(1,1)); output (14,14) ch0 = 29*31+29 = 928; frame_done one cycle after the 961st beat.
- All channels negative: pixel(r,c) = -(r*31+c) -> every output equals the top-left sample of its window; output (0,0) = 0, output (1,1) = -64.
- Random in_valid gaps (about 50% duty) on the same frame as test 1 -> output sequence is identical to the gapless run.
- Row 30 and column 30 set to 0x7FFF, all other pixels 0 -> no output ever equals 0x7FFF (dropped edge verified).
- frame_start pulsed after 100 beats, then a full frame -> no frame_done for the partial frame; the full frame yields 225 correct outputs. Repeat with rst_n asserted mid-frame -> out_valid=0 and busy=0 immediately.
- MAXPOOL_AVG_MODE_EN defined; window values {4,5,6,7} -> 5. Window values {-1,-1,-1,-2} -> -2 (floor of -5/4).
